// File: rtl/fifo_read_packer.sv
// Drains a synchronous FIFO with a 1-cycle read latency and packs PACK words into one wide beat.
// A flush request emits whatever partial beat is held, with out_keep marking the filled lanes.
module fifo_read_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  input  logic                       flush,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]            out_keep,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);

  localparam int CW = $clog2(PACK + 1);
  localparam logic [CW-1:0] FILL_FULL = PACK[CW-1:0];
  localparam logic [CW:0]   PACK_W    = PACK[CW:0];

  logic                             inflight;
  logic                             flush_pend;
  logic [CW-1:0]                    fill;
  logic [CW-1:0]                    fill_eff;
  logic [PACK-1:0][DATA_WIDTH-1:0]  acc;
  logic [PACK-1:0][DATA_WIDTH-1:0]  part_data;
  logic [PACK-1:0]                  part_keep;
  logic                             out_free;
  logic                             xfer_full;
  logic                             xfer_part;
  logic [CW:0]                      room_sum;

  assign out_free  = !out_valid || out_ready;
  assign xfer_full = (fill == FILL_FULL) && out_free;
  assign xfer_part = flush_pend && !inflight && (fill != '0) && (fill < FILL_FULL) && out_free;
  assign fill_eff  = xfer_full ? '0 : fill;

  // Reads in flight count against free lanes so the accumulator can never overflow.
  // A flush request blocks reads in the very cycle it arrives.
  assign room_sum   = {1'b0, fill_eff} + {{CW{1'b0}}, inflight};
  assign fifo_rd_en = !rst && !fifo_empty && !flush && !flush_pend && (room_sum < PACK_W);

  assign busy = (fill != '0) || inflight || out_valid || flush_pend;

  always_comb begin
    part_data = '0;
    part_keep = '0;
    for (int i = 0; i < PACK; i++) begin
      if (CW'(i) < fill) begin
        part_data[i] = acc[i];
        part_keep[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      fill       <= '0;
      inflight   <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;

      if (xfer_full) begin
        out_data  <= acc;
        out_keep  <= '1;
        out_valid <= 1'b1;
      end else if (xfer_part) begin
        out_data  <= part_data;
        out_keep  <= part_keep;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A word landing alongside a full transfer starts the next beat in lane 0.
      if (inflight) begin
        for (int i = 0; i < PACK; i++) begin
          if (fill_eff == CW'(i)) acc[i] <= fifo_data;
        end
        fill <= fill_eff + CW'(1);
      end else if (xfer_full || xfer_part) begin
        fill <= '0;
      end

      if (flush_pend) begin
        if (xfer_part || ((fill == '0) && !inflight && !xfer_full)) flush_pend <= 1'b0;
      end else if (flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_packer.sv
// Bench for fifo_read_packer: a queue-style FIFO model feeds the DUT; emitted beats are
// checked against the ordered word stream, plus directed timing checks.
module tb_fifo_read_packer;
  localparam int DW = 8;
  localparam int PK = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           fifo_empty;
  logic           fifo_rd_en;
  logic [DW-1:0]  fifo_data = '0;
  logic           flush = 1'b0;
  logic [DW*PK-1:0] out_data;
  logic [PK-1:0]  out_keep;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           busy;

  logic [7:0]  fmem  [0:1023];
  logic [7:0]  exp_w [0:1023];
  logic [31:0] bt_data [0:1023];
  logic [3:0]  bt_keep [0:1023];
  int wr_ptr = 0, rd_ptr = 0;
  int exp_wr = 0, exp_rd = 0;
  int beat_cnt = 0, rd_cnt = 0, viol_cnt = 0;
  int chk_idx = 0, part_seen = 0, flush_cnt = 0;
  int n_cmp = 0, n_err = 0;

  fifo_read_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .flush      (flush),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, one cycle after r_en.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= fmem[rd_ptr[9:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (fifo_rd_en) rd_cnt++;
    if (fifo_rd_en && (fifo_empty || rst)) viol_cnt++;
    if (!rst && out_valid && out_ready) begin
      bt_data[beat_cnt[9:0]] = out_data;
      bt_keep[beat_cnt[9:0]] = out_keep;
      beat_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fmem[wr_ptr[9:0]]  = d;
    exp_w[exp_wr[9:0]] = d;
    wr_ptr++;
    exp_wr++;
  endtask

  // Reference: beats must carry the written words in order, lane 0 first,
  // with a contiguous keep mask; partial beats only as a result of a flush.
  task automatic check_beats();
    logic [31:0] d;
    logic [3:0]  k;
    while (chk_idx < beat_cnt) begin
      d = bt_data[chk_idx[9:0]];
      k = bt_keep[chk_idx[9:0]];
      chk("keep_contig", 32'((k == 4'h1) || (k == 4'h3) || (k == 4'h7) || (k == 4'hF)), 32'd1);
      if (k != 4'hF) begin
        part_seen++;
        chk("partial_needs_flush", 32'(part_seen <= flush_cnt), 32'd1);
      end
      for (int i = 0; i < PK; i++) begin
        if (k[i]) begin
          chk("word_available", 32'(exp_rd < exp_wr), 32'd1);
          if (exp_rd < exp_wr) begin
            chk("lane_word", 32'(d[i*DW +: DW]), 32'(exp_w[exp_rd[9:0]]));
            exp_rd++;
          end
        end else begin
          chk("pad_zero", 32'(d[i*DW +: DW]), 32'd0);
        end
      end
      chk_idx++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_beats();
  endtask

  task automatic wait_beats(input int target, input string tag);
    int c;
    c = 0;
    while (beat_cnt < target && c < 300) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk(tag, 32'(beat_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while ((busy || !fifo_empty) && c < 300) begin
      tick();
      c++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, r0, c, pushed;
    pushed = 0;

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk); #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_keep", 32'(out_keep), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    tick();
    rst = 1'b0;

    // single full beat
    tick();
    b0 = beat_cnt;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_beats(b0 + 1, "t1_beat");
    chk("t1_data", bt_data[b0[9:0]], 32'h44332211);
    chk("t1_keep", 32'(bt_keep[b0[9:0]]), 32'hF);
    wait_idle("t1_idle");
    chk("t1_no_empty_read", viol_cnt, 32'd0);

    // streaming throughput
    tick();
    b0 = beat_cnt;
    r0 = rd_cnt;
    for (int i = 1; i <= 8; i++) push(8'(i));
    c = 0;
    while (rd_cnt == r0 && c < 20) begin @(negedge clk); #1; c++; end
    repeat (4) begin @(negedge clk); #1; end
    chk("t2_reads_first5", rd_cnt - r0, 32'd4);
    repeat (5) begin @(negedge clk); #1; end
    chk("t2_reads_first10", rd_cnt - r0, 32'd8);
    wait_beats(b0 + 2, "t2_beats");
    chk("t2_beat0", bt_data[b0[9:0]], 32'h04030201);
    chk("t2_beat1", bt_data[(b0 + 1) % 1024], 32'h08070605);
    wait_idle("t2_idle");

    // backpressure: first beat held, accumulator fills, reads stop
    tick();
    out_ready = 1'b0;
    b0 = beat_cnt;
    r0 = rd_cnt;
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (20) begin
      @(negedge clk); #1;
      if (out_valid) chk("t3_hold_data", out_data, 32'h04030201);
    end
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_keep", 32'(out_keep), 32'hF);
    chk("t3_rd_en_low", 32'(fifo_rd_en), 32'd0);
    chk("t3_reads", rd_cnt - r0, 32'd8);
    chk("t3_no_accept", beat_cnt - b0, 32'd0);
    tick();
    out_ready = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("t3_second_valid", 32'(out_valid), 32'd1);
    chk("t3_second_data", out_data, 32'h08070605);
    wait_beats(b0 + 2, "t3_beats");
    chk("t3_beat0", bt_data[b0[9:0]], 32'h04030201);
    wait_idle("t3_idle");

    // flush of a two-word partial beat
    tick();
    b0 = beat_cnt;
    r0 = rd_cnt;
    push(8'hAA); push(8'hBB);
    c = 0;
    while (rd_cnt < r0 + 2 && c < 20) begin @(negedge clk); #1; c++; end
    chk("t4_two_reads", rd_cnt - r0, 32'd2);
    tick();
    flush = 1'b1;
    flush_cnt++;
    tick();
    flush = 1'b0;
    wait_beats(b0 + 1, "t4_beat");
    chk("t4_data", bt_data[b0[9:0]], 32'h0000BBAA);
    chk("t4_keep", 32'(bt_keep[b0[9:0]]), 32'h3);
    tick();
    @(negedge clk); #1;
    chk("t4_busy_low", 32'(busy), 32'd0);

    // flush with nothing held
    tick();
    b0 = beat_cnt;
    flush = 1'b1;
    flush_cnt++;
    tick();
    flush = 1'b0;
    @(negedge clk); #1;
    chk("t5_pend_busy", 32'(busy), 32'd1);
    chk("t5_no_valid_a", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk); #1;
    chk("t5_pend_clear", 32'(busy), 32'd0);
    chk("t5_no_valid_b", 32'(out_valid), 32'd0);
    chk("t5_no_beat", beat_cnt - b0, 32'd0);

    // reset while a read is in flight
    tick();
    r0 = rd_cnt;
    push(8'h99);
    c = 0;
    while (rd_cnt == r0 && c < 20) begin @(negedge clk); #1; c++; end
    chk("t6_read_seen", rd_cnt - r0, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    exp_rd = exp_wr;
    push(8'h10); push(8'h11); push(8'h12); push(8'h13);
    @(negedge clk); #1;
    chk("t6_rd_en_in_rst", 32'(fifo_rd_en), 32'd0);
    chk("t6_valid_in_rst", 32'(out_valid), 32'd0);
    chk("t6_busy_in_rst", 32'(busy), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    b0 = beat_cnt;
    wait_beats(b0 + 1, "t6_beat");
    chk("t6_data", bt_data[b0[9:0]], 32'h13121110);
    chk("t6_keep", 32'(bt_keep[b0[9:0]]), 32'hF);
    wait_idle("t6_idle");

    // randomized traffic, backpressure and flushes
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      flush = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (pushed < 60 && $urandom_range(0, 2) == 0) begin
        push(8'($urandom));
        pushed++;
      end
      if ($urandom_range(0, 29) == 0) begin
        flush = 1'b1;
        flush_cnt++;
      end
    end
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while (!fifo_empty && c < 200) begin tick(); c++; end
    repeat (3) tick();
    flush = 1'b1;
    flush_cnt++;
    tick();
    flush = 1'b0;
    wait_idle("rand_drain");
    repeat (2) tick();
    check_beats();
    chk("all_words_out", exp_rd, exp_wr);
    chk("no_empty_read", viol_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
